// File: rtl/bp_lce_out_arbiter.sv
// Round-robin arbiter that feeds one outbound LCE-to-CCE link from num_req_p sources
// through a one-entry output buffer, with a back-pressure stall indication.
module bp_lce_out_arbiter #(
  parameter int unsigned num_req_p     = 2,
  parameter int unsigned data_width_p  = 128,
  parameter int unsigned stall_limit_p = 8,
  localparam int unsigned lg_num_req_lp  = (num_req_p == 1) ? 1 : $clog2(num_req_p),
  localparam int unsigned stall_cnt_w_lp = (stall_limit_p + 1 == 1) ? 1 : $clog2(stall_limit_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_yumi_o,
  output logic [data_width_p-1:0]           link_data_o,
  output logic                              link_v_o,
  input  logic                              link_ready_i,
  output logic [lg_num_req_lp-1:0]          link_src_o,
  output logic                              stall_o
);

  typedef enum logic {e_empty, e_full} state_e;

  state_e                    state_q;
  logic [data_width_p-1:0]   data_q;
  logic [lg_num_req_lp-1:0]  src_q;
  logic [lg_num_req_lp-1:0]  last_q;
  logic [stall_cnt_w_lp-1:0] stall_cnt_q;

  logic                      can_load;
  logic                      any_v;
  logic                      grant;
  logic                      hi_found;
  logic                      lo_found;
  logic [lg_num_req_lp-1:0]  hi_idx;
  logic [lg_num_req_lp-1:0]  lo_idx;
  logic [lg_num_req_lp-1:0]  gnt;
  logic [data_width_p-1:0]   sel_data;

  assign any_v    = |req_v_i;
  assign can_load = (state_q == e_empty) | link_ready_i;
  assign grant    = can_load & any_v & ~reset_i;

  // Round-robin search split in two passes: the lowest requester above last_q wins,
  // otherwise the search wraps to the lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (req_v_i[i]) begin
        if (!lo_found) begin
          lo_idx   = lg_num_req_lp'(i);
          lo_found = 1'b1;
        end
        if (!hi_found && (lg_num_req_lp'(i) > last_q)) begin
          hi_idx   = lg_num_req_lp'(i);
          hi_found = 1'b1;
        end
      end
    end
    gnt = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_data   = '0;
    req_yumi_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (lg_num_req_lp'(i) == gnt) begin
        sel_data      = req_data_i[i*data_width_p +: data_width_p];
        req_yumi_o[i] = grant;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_empty;
      data_q      <= '0;
      src_q       <= '0;
      last_q      <= lg_num_req_lp'(num_req_p - 1);
      stall_cnt_q <= '0;
    end else begin
      if ((state_q == e_full) && !link_ready_i) begin
        if (stall_cnt_q != stall_cnt_w_lp'(stall_limit_p))
          stall_cnt_q <= stall_cnt_q + stall_cnt_w_lp'(1);
      end else begin
        stall_cnt_q <= '0;
      end

      if (grant) begin
        state_q <= e_full;
        data_q  <= sel_data;
        src_q   <= gnt;
        last_q  <= gnt;
      end else if (link_ready_i) begin
        state_q <= e_empty;
      end
    end
  end

  assign link_data_o = data_q;
  assign link_src_o  = src_q;
  assign link_v_o    = (state_q == e_full);
  assign stall_o     = (stall_cnt_q == stall_cnt_w_lp'(stall_limit_p));

endmodule

// File: tb/tb_bp_lce_out_arbiter.sv
// Bench for bp_lce_out_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural buffer/priority model.
module tb_bp_lce_out_arbiter;
  localparam int N = 3;
  localparam int W = 16;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_v;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   yumi;
  logic [W-1:0]   link_data;
  logic           link_v;
  logic           link_ready;
  logic [1:0]     link_src;
  logic           stall;

  always #5 clk = ~clk;

  bp_lce_out_arbiter #(
    .num_req_p    (N),
    .data_width_p (W),
    .stall_limit_p(L)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_v_i     (req_v),
    .req_data_i  (req_data),
    .req_yumi_o  (yumi),
    .link_data_o (link_data),
    .link_v_o    (link_v),
    .link_ready_i(link_ready),
    .link_src_o  (link_src),
    .stall_o     (stall)
  );

  int tests = 0;
  int fails = 0;

  logic         src_v [N];
  logic [W-1:0] src_d [N];
  logic [N-1:0] last_yumi;
  int           grants[$];

  // model state: buffer contents, priority pointer, consecutive held cycles
  logic         m_v;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_last;
  int           m_hold;

  int           best, bestd, d;
  logic [N-1:0] ey;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    last_yumi = yumi;
    for (int i = 0; i < N; i++) if (yumi[i] === 1'b1) grants.push_back(i);
    if (reset) begin
      m_v = 1'b0; m_data = '0; m_src = 0; m_last = N - 1; m_hold = 0;
      chk("yumi_in_reset", yumi, 0);
      chk("link_v_in_reset", link_v, 0);
    end else begin
      best = -1; bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i + N - m_last - 1) % N;
        if (req_v[i] && d < bestd) begin bestd = d; best = i; end
      end
      ey = '0;
      if (best >= 0 && (!m_v || link_ready)) ey[best] = 1'b1;
      chk("yumi", yumi, ey);
      chk("link_v", link_v, m_v);
      chk("link_data", link_data, m_data);
      chk("link_src", link_src, m_src);
      chk("stall", stall, m_hold >= L);
      if (m_v && !link_ready) m_hold++; else m_hold = 0;
      if (ey != 0) begin
        m_v = 1'b1; m_data = src_d[best]; m_src = best; m_last = best;
      end else if (m_v && link_ready) begin
        m_v = 1'b0;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_v[i] = src_v[i];
      req_data[i*W +: W] = src_d[i];
    end
  endtask

  task automatic set_src(input int i, input logic [W-1:0] dat);
    src_v[i] = 1'b1;
    src_d[i] = dat;
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (last_yumi[i]) src_v[i] = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    link_ready = 1'b0;
    for (int i = 0; i < N; i++) src_v[i] = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int fair_exp[8] = '{0, 1, 2, 0, 1, 2, 0, 1};
  int burst;

  initial begin
    reset = 1'b1;
    link_ready = 1'b0;
    last_yumi = '0;
    for (int i = 0; i < N; i++) begin src_v[i] = 1'b0; src_d[i] = '0; end
    drive();
    do_reset();
    #1;
    chk("rst_link_v", link_v, 0);
    chk("rst_link_data", link_data, 0);
    chk("rst_link_src", link_src, 0);
    chk("rst_stall", stall, 0);

    // reset priority: source 0 first, then 1
    grants.delete();
    set_src(0, 16'h000A);
    set_src(1, 16'h000B);
    link_ready = 1'b1;
    tick();
    chk("prio_data0", link_data, 16'h000A);
    chk("prio_src0", link_src, 0);
    tick();
    chk("prio_data1", link_data, 16'h000B);
    chk("prio_src1", link_src, 1);
    chk("prio_order_n", grants.size(), 2);
    chk("prio_order0", grants[0], 0);
    chk("prio_order1", grants[1], 1);
    tick();
    chk("drain_link_v", link_v, 0);
    chk("drain_stall", stall, 0);

    // back-pressure with a waiting source, then drain and refill together
    set_src(2, 16'h00C3);
    tick();
    chk("bp_loaded", link_data, 16'h00C3);
    link_ready = 1'b0;
    set_src(0, 16'h00D4);
    for (int h = 1; h <= 10; h++) begin
      #1;
      chk("bp_yumi", yumi, 0);
      chk("bp_data_stable", link_data, 16'h00C3);
      chk("bp_stall", stall, h >= 9);
      tick();
    end
    link_ready = 1'b1;
    #1;
    chk("bp_stall_before_accept", stall, 1);
    chk("bp_refill_yumi", yumi, 3'b001);
    tick();
    chk("bp_stall_after_accept", stall, 0);
    chk("bp_refill_v", link_v, 1);
    chk("bp_refill_data", link_data, 16'h00D4);
    tick();
    chk("bp_drain_v", link_v, 0);

    // fairness with all sources busy, then the idle-pointer check
    do_reset();
    grants.delete();
    link_ready = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, W'(16'h0100 + i));
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 5)
        for (int i = 0; i < N; i++) if (!src_v[i]) set_src(i, W'($urandom));
    end
    repeat (2) tick();
    repeat (5) tick();
    chk("fair_n", grants.size(), 8);
    for (int k = 0; k < 8; k++) chk("fair_order", grants[k], fair_exp[k]);
    grants.delete();
    for (int i = 0; i < N; i++) set_src(i, W'(16'h0200 + i));
    tick();
    chk("sparse_first", grants[0], 2);
    repeat (4) tick();

    // asynchronous reset while a message is held
    do_reset();
    set_src(0, 16'h00E5);
    tick();
    chk("mr_loaded", link_v, 1);
    link_ready = 1'b0;
    set_src(0, 16'h00F6);
    set_src(1, 16'h0017);
    repeat (2) tick();
    #1 reset = 1'b1;
    #1;
    chk("mr_link_v", link_v, 0);
    chk("mr_yumi", yumi, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    grants.delete();
    link_ready = 1'b1;
    tick();
    chk("mr_contest", grants[0], 0);
    repeat (3) tick();

    // randomized traffic with back-pressure bursts and occasional resets
    burst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (burst > 0) begin
        link_ready = 1'b0;
        burst--;
      end else begin
        link_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 63) == 0) burst = 12;
      end
      for (int i = 0; i < N; i++)
        if (!src_v[i] && $urandom_range(0, 3) == 0) set_src(i, W'($urandom));
      drive();
      if (cyc % 1000 == 999) begin
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) if (last_yumi[i]) src_v[i] = 1'b0;
        drive();
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_lce_out_arbiter.md
# bp_lce_out_arbiter

Shares one outbound LCE-to-CCE network link between `num_req_p` message sources, such as the front-end and back-end LCE request engines or an LCE's request and response senders. It selects one pending source per cycle using round-robin priority and registers the chosen message in a one-entry output buffer. It then presents the buffered message on the link with a valid/ready handshake. It also raises a stall indication when the link has back-pressured a held message for too long.

## Interface
Parameters:
- `num_req_p`, default 2: number of sources; must be ≥ 2.
- `data_width_p`, default 128: width of one message in bits; messages are opaque.
- `stall_limit_p`, default 8: number of back-pressured hold cycles at which `stall_o` asserts; must be ≥ 1.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `reset_i`, input, 1: reset, asynchronous and active-high.
- `req_v_i`, input, `num_req_p`: per-source message valid.
- `req_data_i`, input, `num_req_p*data_width_p`: messages packed by source; source i occupies bits `[i*data_width_p +: data_width_p]`.
- `req_yumi_o`, output, `num_req_p`: one-hot or zero; the source's message is consumed this cycle.
- `link_data_o`, output, `data_width_p`: buffered message.
- `link_v_o`, output, 1: buffer holds a message.
- `link_ready_i`, input, 1: link accepts a message when `link_v_o & link_ready_i`.
- `link_src_o`, output, `BSG_SAFE_CLOG2(num_req_p)`: index of the source that supplied the buffered message.
- `stall_o`, output, 1: held message has been back-pressured for `stall_limit_p` or more consecutive cycles.

## Operation
- Two states, derived from buffer valid `v_r`:
  - `e_empty` (`v_r=0`).
  - `e_full` (`v_r=1`).
- Buffer may load when `can_load = ~v_r | link_ready_i`, so drain and refill can happen in the same cycle.
- Round-robin pointer `last_r` holds the last granted index.
- Search order is `last_r+1, last_r+2, …`, wrapping modulo `num_req_p`. The first index with `req_v_i` set wins and becomes `gnt`.
- `req_yumi_o[gnt] = can_load & |req_v_i`; all other yumi bits are 0.
- On yumi, at the clock edge:
  - `data_r <= req_data_i[gnt]`.
  - `src_r <= gnt`.
  - `last_r <= gnt`.
  - `v_r <= 1`.
- Drain with no refill (`v_r & link_ready_i & ~|req_v_i`) sets `v_r <= 0`.
- `last_r` updates only on a grant. Idle cycles do not rotate priority.
- Stall counter `stall_cnt_r`, width `BSG_SAFE_CLOG2(stall_limit_p+1)`:
  - Increments when `v_r & ~link_ready_i`.
  - Saturates at `stall_limit_p`.
  - Clears to 0 on any cycle with `~v_r | link_ready_i`.
- `stall_o = (stall_cnt_r == stall_limit_p)`.
- `link_data_o = data_r`, `link_src_o = src_r`, `link_v_o = v_r`. Data and source are stable while `v_r & ~link_ready_i`.
- `req_yumi_o` is combinational from `req_v_i`, `link_ready_i` and state. It has no dependence on the sources' data.
- Sources follow the yumi contract: valid must not depend on yumi, and a valid message holds until yumi is seen.

## Timing
- Reset values:
  - `v_r=0`, so `link_v_o=0`.
  - `link_data_o=0`, `link_src_o=0`.
  - `last_r=num_req_p-1`, so source 0 has first priority after reset.
  - `stall_cnt_r=0`, `stall_o=0`.
  - `req_yumi_o=0` whenever `reset_i` is high.
- Reset is asynchronous. Asserting it mid-operation discards any buffered message in that cycle, with no yumi and no link transfer.
- Latency: yumi in cycle N, message valid on the link in cycle N+1.
- Throughput: one message per cycle when `link_ready_i` is held high.
- Full with link not ready: every yumi bit is 0, and sources hold.
- Simultaneous drain and grant:
  - Link transfer of the old message and yumi of the new message occur in the same cycle.
  - `link_v_o` stays 1.
  - `stall_cnt_r` clears.
- Single requester: it is granted every loadable cycle regardless of `last_r`.
- `stall_o` first asserts in the cycle after the `stall_limit_p`-th consecutive back-pressured cycle. It deasserts in the cycle after the link accepts the message.

## Test plan
- **Reset priority.** Reset, then `req_v_i=2'b11` with data 0xA and 0xB, `link_ready_i=1` → yumi 01 then 10. The link shows A (src 0) then B (src 1) on consecutive cycles.
- **Back-pressure.** Buffer full, `link_ready_i=0` for 10 cycles, `stall_limit_p=8` →
  - yumi stays 0.
  - `link_data_o` is stable.
  - `stall_o` is 1 from the 9th cycle of hold onward.
  - After `link_ready_i=1`: transfer occurs, `stall_o=0` the next cycle.
- **Fairness.** `num_req_p=3`, all valid continuously, `link_ready_i=1` for 6 cycles → grant order 0,1,2,0,1,2.
- **Sparse requests.** Grant to 1, idle 5 cycles, then `req_v_i=3'b111` → grant to 2 (the pointer did not rotate while idle).
- **Drain with no refill.** Full buffer, `link_ready_i=1`, `req_v_i=0` → one transfer, then `link_v_o=0` and `stall_o=0`.
- **Mid-stream reset.** Assert `reset_i` asynchronously with a message held and `link_ready_i=0` →
  - `link_v_o` drops to 0 immediately.
  - After release, source 0 wins a contested grant.
